// File: rtl/vending_machine_multi_if.sv
// Front-end / dispenser bus for the multi-product vending controller.
// The master drives coin, keypad and session strobes; the slave reports vend results.
interface vending_machine_multi_if #(
  parameter int ITEMS   = 4,
  parameter int MONEY_W = 8
);
  localparam int SEL_W = $clog2(ITEMS);

  logic               start;
  logic               coin_valid;
  logic [3:0]         data_in;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               cancel;
  logic               dispense;
  logic [SEL_W-1:0]   item_number;
  logic               change_valid;
  logic [MONEY_W-1:0] change;
  logic [MONEY_W-1:0] credit;
  logic [1:0]         state;
  logic               coin_reject;
  logic               sel_reject;
  logic [ITEMS-1:0]   sold_out;

  modport master (
    output start, coin_valid, data_in,
    output sel_valid, sel, cancel,
    input  dispense, item_number,
    input  change_valid, change, credit,
    input  state, coin_reject, sel_reject,
    input  sold_out
  );

  modport slave (
    input  start, coin_valid, data_in,
    input  sel_valid, sel, cancel,
    output dispense, item_number,
    output change_valid, change, credit,
    output state, coin_reject, sel_reject,
    output sold_out
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: per-item price and stock,
// capped credit, cancel/refund and change return.
module vending_machine_multi #(
  parameter int ITEMS   = 4,
  parameter int MONEY_W = 8,
  parameter int STOCK_W = 4,
  parameter logic [ITEMS*MONEY_W-1:0] PRICES =
    {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int INIT_STOCK = 5,
  parameter int MAX_CREDIT = 99
) (
  input logic clk,
  input logic rst,
  vending_machine_multi_if.slave bus
);
  localparam int SEL_W = $clog2(ITEMS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]   item_q, item_d;
  logic               coin_rej_q, coin_rej_d;
  logic               sel_rej_q, sel_rej_d;
  logic [STOCK_W-1:0] stock_q [ITEMS];
  logic [STOCK_W-1:0] stock_d [ITEMS];

  logic               sel_in;
  logic [STOCK_W-1:0] sel_stock;
  logic [MONEY_W-1:0] sel_price;
  logic [MONEY_W-1:0] vend_price;
  logic [MONEY_W:0]   sum;
  logic [ITEMS-1:0]   empty;

  // Explicit muxes keep out-of-range selects harmless
  always_comb begin
    sel_in     = 1'b0;
    sel_stock  = '0;
    sel_price  = '0;
    vend_price = '0;
    for (int i = 0; i < ITEMS; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_in    = 1'b1;
        sel_stock = stock_q[i];
        sel_price = PRICES[i*MONEY_W +: MONEY_W];
      end
      if (item_q == SEL_W'(i))
        vend_price = PRICES[i*MONEY_W +: MONEY_W];
    end
  end

  assign sum = {1'b0, credit_q} + (MONEY_W+1)'(bus.data_in);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_d     = item_q;
    coin_rej_d = 1'b0;
    sel_rej_d  = 1'b0;
    stock_d    = stock_q;
    unique case (state_q)
      IDLE: begin
        credit_d = '0;
        if (bus.start) state_d = COLLECT;
      end
      COLLECT: begin
        if (bus.cancel || !bus.start) begin
          state_d    = CHANGE;
          coin_rej_d = bus.coin_valid;
        end else if (bus.sel_valid) begin
          coin_rej_d = bus.coin_valid;
          if (!sel_in || sel_stock == '0 ||
              credit_q < sel_price) begin
            sel_rej_d = 1'b1;
          end else begin
            item_d  = bus.sel;
            state_d = VEND;
          end
        end else if (bus.coin_valid) begin
          if (bus.data_in != 4'd0 &&
              sum <= (MONEY_W+1)'(MAX_CREDIT))
            credit_d = sum[MONEY_W-1:0];
          else
            coin_rej_d = 1'b1;
        end
      end
      VEND: begin
        credit_d   = credit_q - vend_price;
        coin_rej_d = bus.coin_valid;
        state_d    = CHANGE;
        for (int i = 0; i < ITEMS; i++)
          if (item_q == SEL_W'(i))
            stock_d[i] = stock_q[i] - 1'b1;
      end
      CHANGE: begin
        credit_d   = '0;
        coin_rej_d = bus.coin_valid;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item_q     <= '0;
      coin_rej_q <= 1'b0;
      sel_rej_q  <= 1'b0;
      for (int i = 0; i < ITEMS; i++)
        stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      coin_rej_q <= coin_rej_d;
      sel_rej_q  <= sel_rej_d;
      for (int i = 0; i < ITEMS; i++)
        stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    empty = '0;
    for (int i = 0; i < ITEMS; i++)
      empty[i] = (stock_q[i] == '0);
  end

  assign bus.dispense     = (state_q == VEND);
  assign bus.change_valid = (state_q == CHANGE);
  assign bus.change       = (state_q == CHANGE) ? credit_q : '0;
  assign bus.item_number  = item_q;
  assign bus.credit       = credit_q;
  assign bus.state        = state_q;
  assign bus.coin_reject  = coin_rej_q;
  assign bus.sel_reject   = sel_rej_q;
  assign bus.sold_out     = empty;
endmodule
